// File: rtl/stamofu_iq_gen2_if.sv
// stamofu_iq_gen2_if: dispatch, writeback snoop, issue, flush and PRF request bundle for the STAMOFU issue queue.
interface stamofu_iq_gen2_if #(
    parameter int IQ_ENTRIES = 4,
    parameter int LOG_PR_COUNT = 7,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_CQ_ENTRIES = 4
);
    localparam int PRF_BANK_COUNT = 2 ** LOG_PRF_BANK_COUNT;
    localparam int UPPER_W = LOG_PR_COUNT - LOG_PRF_BANK_COUNT;
    localparam int OCC_W = $clog2(IQ_ENTRIES + 1);
    logic enq_valid, enq_is_store, enq_is_amo, enq_is_fence;
    logic [3:0] enq_op;
    logic [11:0] enq_imm12;
    logic [LOG_PR_COUNT-1:0] enq_A_PR, enq_B_PR;
    logic enq_A_ready, enq_B_ready, enq_A_is_zero, enq_B_is_zero;
    logic [LOG_CQ_ENTRIES-1:0] enq_cq_index;
    logic enq_ready;
    logic [PRF_BANK_COUNT-1:0] WB_bus_valid_by_bank;
    logic [PRF_BANK_COUNT-1:0][UPPER_W-1:0] WB_bus_upper_PR_by_bank;
    logic issue_valid, issue_is_store, issue_is_amo, issue_is_fence;
    logic [3:0] issue_op;
    logic [11:0] issue_imm12;
    logic issue_A_forward, issue_B_forward, issue_A_is_zero, issue_B_is_zero;
    logic [LOG_PRF_BANK_COUNT-1:0] issue_A_bank, issue_B_bank;
    logic [LOG_CQ_ENTRIES-1:0] issue_cq_index;
    logic PRF_req_A_valid, PRF_req_B_valid;
    logic [LOG_PR_COUNT-1:0] PRF_req_A_PR, PRF_req_B_PR;
    logic pipeline_ready, flush_valid;
    logic [LOG_CQ_ENTRIES-1:0] flush_cq_index, flush_cq_head;
    logic [OCC_W-1:0] occupancy;

    modport master (
        output enq_valid, enq_is_store, enq_is_amo, enq_is_fence, enq_op, enq_imm12,
               enq_A_PR, enq_B_PR, enq_A_ready, enq_B_ready, enq_A_is_zero, enq_B_is_zero, enq_cq_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, pipeline_ready,
               flush_valid, flush_cq_index, flush_cq_head,
        input  enq_ready, issue_valid, issue_is_store, issue_is_amo, issue_is_fence, issue_op, issue_imm12,
               issue_A_forward, issue_B_forward, issue_A_is_zero, issue_B_is_zero,
               issue_A_bank, issue_B_bank, issue_cq_index,
               PRF_req_A_valid, PRF_req_B_valid, PRF_req_A_PR, PRF_req_B_PR, occupancy
    );
    modport slave (
        input  enq_valid, enq_is_store, enq_is_amo, enq_is_fence, enq_op, enq_imm12,
               enq_A_PR, enq_B_PR, enq_A_ready, enq_B_ready, enq_A_is_zero, enq_B_is_zero, enq_cq_index,
               WB_bus_valid_by_bank, WB_bus_upper_PR_by_bank, pipeline_ready,
               flush_valid, flush_cq_index, flush_cq_head,
        output enq_ready, issue_valid, issue_is_store, issue_is_amo, issue_is_fence, issue_op, issue_imm12,
               issue_A_forward, issue_B_forward, issue_A_is_zero, issue_B_is_zero,
               issue_A_bank, issue_B_bank, issue_cq_index,
               PRF_req_A_valid, PRF_req_B_valid, PRF_req_A_PR, PRF_req_B_PR, occupancy
    );
endinterface

// File: rtl/stamofu_iq_gen2.sv
// stamofu_iq_gen2: compacting in-order store/AMO/fence issue queue with writeback wakeup and CQ-age flush.
module stamofu_iq_gen2 #(
    parameter int IQ_ENTRIES = 4,
    parameter int LOG_PR_COUNT = 7,
    parameter int LOG_PRF_BANK_COUNT = 2,
    parameter int LOG_CQ_ENTRIES = 4
) (
    input logic CLK,
    input logic RST,
    stamofu_iq_gen2_if.slave bus
);
    localparam int PB = LOG_PRF_BANK_COUNT;
    localparam int OW = $clog2(IQ_ENTRIES + 1);
    localparam int SW = $clog2(IQ_ENTRIES);

    typedef struct packed {
        logic is_store, is_amo, is_fence;
        logic [3:0] op;
        logic [11:0] imm12;
        logic [LOG_PR_COUNT-1:0] a_pr, b_pr;
        logic a_ready, b_ready, a_zero, b_zero;
        logic [LOG_CQ_ENTRIES-1:0] cq;
    } entry_t;

    entry_t q [IQ_ENTRIES];
    entry_t nxt [IQ_ENTRIES];
    entry_t woken [IQ_ENTRIES+1];
    entry_t enq_e, sel_e;
    logic [OW-1:0] occ, occ_nxt, surv;
    logic [SW-1:0] sel;
    logic [LOG_CQ_ENTRIES-1:0] flush_age;
    logic found, issue, enq_ok, accept, a_fwd, b_fwd;

    function automatic logic wake(input logic [LOG_PR_COUNT-1:0] pr);
        return bus.WB_bus_valid_by_bank[pr[PB-1:0]] &&
               bus.WB_bus_upper_PR_by_bank[pr[PB-1:0]] == pr[LOG_PR_COUNT-1:PB];
    endfunction

    assign flush_age = bus.flush_cq_index - bus.flush_cq_head;
    assign enq_ok = !RST && !bus.flush_valid && occ < OW'(IQ_ENTRIES);
    assign accept = bus.enq_valid && enq_ok;
    assign issue = found && bus.pipeline_ready && !bus.flush_valid && !RST;
    assign enq_e = entry_t'{
        is_store: bus.enq_is_store, is_amo: bus.enq_is_amo, is_fence: bus.enq_is_fence,
        op: bus.enq_op, imm12: bus.enq_imm12, a_pr: bus.enq_A_PR, b_pr: bus.enq_B_PR,
        a_ready: bus.enq_A_ready | wake(bus.enq_A_PR), b_ready: bus.enq_B_ready | wake(bus.enq_B_PR),
        a_zero: bus.enq_A_is_zero, b_zero: bus.enq_B_is_zero, cq: bus.enq_cq_index};

    // Descending scan so the last hit is the oldest eligible entry.
    always_comb begin
        found = 1'b0;
        sel = '0;
        surv = '0;
        woken[IQ_ENTRIES] = '0;
        for (int i = IQ_ENTRIES - 1; i >= 0; i--) begin
            woken[i] = q[i];
            woken[i].a_ready = q[i].a_ready | wake(q[i].a_pr);
            woken[i].b_ready = q[i].b_ready | wake(q[i].b_pr);
            if (i < int'(occ) && (woken[i].a_ready || q[i].a_zero) && (woken[i].b_ready || q[i].b_zero)) begin
                found = 1'b1;
                sel = SW'(i);
            end
            if (i < int'(occ) && q[i].cq - bus.flush_cq_head < flush_age) surv = surv + 1'b1;
        end
    end

    always_comb begin
        for (int i = 0; i < IQ_ENTRIES; i++) begin
            nxt[i] = issue && i >= int'(sel) ? woken[i+1] : woken[i];
            if (accept && i == int'(occ) - int'(issue)) nxt[i] = enq_e;
        end
        occ_nxt = bus.flush_valid ? surv : occ + OW'(accept) - OW'(issue);
    end

    assign sel_e = found ? q[sel] : '0;
    assign a_fwd = found && !sel_e.a_ready && !sel_e.a_zero && wake(sel_e.a_pr);
    assign b_fwd = found && !sel_e.b_ready && !sel_e.b_zero && wake(sel_e.b_pr);

    assign bus.enq_ready = enq_ok;
    assign bus.issue_valid = issue;
    assign bus.issue_is_store = sel_e.is_store;
    assign bus.issue_is_amo = sel_e.is_amo;
    assign bus.issue_is_fence = sel_e.is_fence;
    assign bus.issue_op = sel_e.op;
    assign bus.issue_imm12 = sel_e.imm12;
    assign bus.issue_A_forward = a_fwd;
    assign bus.issue_B_forward = b_fwd;
    assign bus.issue_A_is_zero = sel_e.a_zero;
    assign bus.issue_B_is_zero = sel_e.b_zero;
    assign bus.issue_A_bank = sel_e.a_pr[PB-1:0];
    assign bus.issue_B_bank = sel_e.b_pr[PB-1:0];
    assign bus.issue_cq_index = sel_e.cq;
    assign bus.PRF_req_A_valid = issue && !a_fwd && !sel_e.a_zero;
    assign bus.PRF_req_B_valid = issue && !b_fwd && !sel_e.b_zero;
    assign bus.PRF_req_A_PR = sel_e.a_pr;
    assign bus.PRF_req_B_PR = sel_e.b_pr;
    assign bus.occupancy = occ;

    always_ff @(posedge CLK) begin
        occ <= RST ? '0 : occ_nxt;
        q <= nxt;
    end
endmodule

// File: tb/tb_stamofu_iq_gen2.sv
// tb_stamofu_iq_gen2: directed scenarios plus random traffic checked against a queue-based reference model.
module tb_stamofu_iq_gen2;
    typedef struct {
        bit st, am, fe;
        int op, imm, a, b, cq;
        bit ar, br, az, bz;
    } op_t;

    logic CLK = 1'b0;
    logic RST;
    op_t q[$];
    int next_cq = 0;
    int checks = 0;
    int errors = 0;

    stamofu_iq_gen2_if bus();
    stamofu_iq_gen2 dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit wk(int pr);
        return bus.WB_bus_valid_by_bank[pr % 4] && int'(bus.WB_bus_upper_PR_by_bank[pr % 4]) == pr / 4;
    endfunction

    task automatic set_enq(int a, int b, bit ar, bit br, bit az, bit bz);
        bus.enq_valid = 1'b1;
        bus.enq_is_store = 1'b1;
        bus.enq_is_amo = 1'b0;
        bus.enq_is_fence = 1'b0;
        bus.enq_op = 4'($urandom);
        bus.enq_imm12 = 12'($urandom);
        bus.enq_A_PR = 7'(a);
        bus.enq_B_PR = 7'(b);
        bus.enq_A_ready = ar;
        bus.enq_B_ready = br;
        bus.enq_A_is_zero = az;
        bus.enq_B_is_zero = bz;
        bus.enq_cq_index = 4'(next_cq);
    endtask

    // Compare the current cycle against the model, advance the model, then move to the next negedge.
    task automatic step();
        op_t s, n;
        op_t keep[$];
        int sel, ha;
        bit found, ei, er, acc, fa, fb;
        #1;
        found = 0;
        sel = 0;
        foreach (q[i])
            if (!found && (q[i].ar || q[i].az || wk(q[i].a)) && (q[i].br || q[i].bz || wk(q[i].b))) begin
                found = 1;
                sel = i;
            end
        ei = found && bus.pipeline_ready && !bus.flush_valid && !RST;
        er = !RST && !bus.flush_valid && q.size() < 4;
        acc = bus.enq_valid && er;
        chk("occupancy", bus.occupancy, q.size());
        chk("enq_ready", bus.enq_ready, er);
        chk("issue_valid", bus.issue_valid, ei);
        if (ei) begin
            s = q[sel];
            fa = !s.ar && !s.az && wk(s.a);
            fb = !s.br && !s.bz && wk(s.b);
            chk("issue_cq", bus.issue_cq_index, s.cq);
            chk("issue_class", {bus.issue_is_store, bus.issue_is_amo, bus.issue_is_fence}, {s.st, s.am, s.fe});
            chk("issue_op", bus.issue_op, s.op);
            chk("issue_imm", bus.issue_imm12, s.imm);
            chk("A_forward", bus.issue_A_forward, fa);
            chk("B_forward", bus.issue_B_forward, fb);
            chk("zeros", {bus.issue_A_is_zero, bus.issue_B_is_zero}, {s.az, s.bz});
            chk("banks", {bus.issue_A_bank, bus.issue_B_bank}, {2'(s.a % 4), 2'(s.b % 4)});
            chk("prf_valid", {bus.PRF_req_A_valid, bus.PRF_req_B_valid}, {!fa && !s.az, !fb && !s.bz});
            chk("prf_pr", {bus.PRF_req_A_PR, bus.PRF_req_B_PR}, {7'(s.a), 7'(s.b)});
        end
        if (q.size() == 0) chk("empty_outs", {bus.issue_imm12, bus.issue_cq_index, bus.PRF_req_A_PR}, 0);
        if (RST) q.delete();
        else if (bus.flush_valid) begin
            ha = (int'(bus.flush_cq_index) - int'(bus.flush_cq_head) + 16) % 16;
            foreach (q[i])
                if ((q[i].cq - int'(bus.flush_cq_head) + 16) % 16 < ha) begin
                    n = q[i];
                    n.ar = n.ar | wk(n.a);
                    n.br = n.br | wk(n.b);
                    keep.push_back(n);
                end
            q = keep;
            next_cq = int'(bus.flush_cq_index);
        end else begin
            foreach (q[i]) begin
                n = q[i];
                n.ar = n.ar | wk(n.a);
                n.br = n.br | wk(n.b);
                q[i] = n;
            end
            if (ei) q.delete(sel);
            if (acc) begin
                n.st = bus.enq_is_store;
                n.am = bus.enq_is_amo;
                n.fe = bus.enq_is_fence;
                n.op = int'(bus.enq_op);
                n.imm = int'(bus.enq_imm12);
                n.a = int'(bus.enq_A_PR);
                n.b = int'(bus.enq_B_PR);
                n.ar = bus.enq_A_ready | wk(n.a);
                n.br = bus.enq_B_ready | wk(n.b);
                n.az = bus.enq_A_is_zero;
                n.bz = bus.enq_B_is_zero;
                n.cq = next_cq;
                q.push_back(n);
                next_cq = (next_cq + 1) % 16;
            end
        end
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int c0;
        RST = 1'b1;
        bus.enq_valid = 0; bus.enq_is_store = 0; bus.enq_is_amo = 0; bus.enq_is_fence = 0;
        bus.enq_op = 0; bus.enq_imm12 = 0; bus.enq_A_PR = 0; bus.enq_B_PR = 0;
        bus.enq_A_ready = 0; bus.enq_B_ready = 0; bus.enq_A_is_zero = 0; bus.enq_B_is_zero = 0;
        bus.enq_cq_index = 0; bus.WB_bus_valid_by_bank = 0; bus.WB_bus_upper_PR_by_bank = '0;
        bus.pipeline_ready = 0; bus.flush_valid = 0; bus.flush_cq_index = 0; bus.flush_cq_head = 0;
        @(negedge CLK);
        step();
        step();
        RST = 1'b0;
        // Ready store issues one cycle after enqueue.
        bus.pipeline_ready = 1;
        set_enq(5, 9, 1, 1, 0, 0);
        step();
        bus.enq_valid = 0;
        #1;
        chk("t1_issue", bus.issue_valid, 1);
        chk("t1_bankA", bus.issue_A_bank, 1);
        chk("t1_bankB", bus.issue_B_bank, 1);
        chk("t1_prA", bus.PRF_req_A_PR, 5);
        chk("t1_prB", bus.PRF_req_B_PR, 9);
        chk("t1_fwd", {bus.issue_A_forward, bus.issue_B_forward}, 0);
        chk("t1_occ1", bus.occupancy, 1);
        step();
        #1;
        chk("t1_occ0", bus.occupancy, 0);
        // Operand A woken by bank 2 and forwarded in the same cycle.
        set_enq(14, 0, 0, 0, 0, 1);
        step();
        bus.enq_valid = 0;
        repeat (3) step();
        bus.WB_bus_valid_by_bank = 4'b0100;
        bus.WB_bus_upper_PR_by_bank[2] = 5'd3;
        #1;
        chk("t2_issue", bus.issue_valid, 1);
        chk("t2_fwd", bus.issue_A_forward, 1);
        chk("t2_prfA", bus.PRF_req_A_valid, 0);
        step();
        bus.WB_bus_valid_by_bank = 0;
        // Full queue under backpressure, then in-order drain.
        next_cq = 0;
        bus.pipeline_ready = 0;
        repeat (4) begin
            set_enq(1, 2, 1, 1, 0, 0);
            step();
        end
        set_enq(1, 2, 1, 1, 0, 0);
        #1;
        chk("t3_full_rdy", bus.enq_ready, 0);
        chk("t3_full_occ", bus.occupancy, 4);
        step();
        bus.enq_valid = 0;
        bus.pipeline_ready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("t3_order", bus.issue_cq_index, k);
            step();
        end
        // Younger ready op bypasses a stalled older one.
        c0 = next_cq;
        set_enq(32, 0, 0, 0, 0, 1);
        step();
        set_enq(3, 4, 1, 1, 0, 0);
        step();
        set_enq(6, 7, 1, 1, 0, 0);
        #1;
        chk("t4_ooo", bus.issue_cq_index, c0 + 1);
        step();
        bus.enq_valid = 0;
        bus.pipeline_ready = 0;
        step();
        bus.pipeline_ready = 1;
        bus.WB_bus_valid_by_bank = 4'b0001;
        bus.WB_bus_upper_PR_by_bank[0] = 5'd8;
        #1;
        chk("t4_old", bus.issue_cq_index, c0);
        step();
        bus.WB_bus_valid_by_bank = 0;
        #1;
        chk("t4_new", bus.issue_cq_index, c0 + 2);
        step();
        // Flush across the CQ wrap point.
        next_cq = 14;
        bus.pipeline_ready = 0;
        repeat (4) begin
            set_enq(1, 2, 1, 1, 0, 0);
            step();
        end
        set_enq(1, 2, 1, 1, 0, 0);
        bus.pipeline_ready = 1;
        bus.flush_valid = 1;
        bus.flush_cq_head = 4'd14;
        bus.flush_cq_index = 4'd0;
        #1;
        chk("t5_noissue", bus.issue_valid, 0);
        chk("t5_noenq", bus.enq_ready, 0);
        step();
        bus.flush_valid = 0;
        bus.enq_valid = 0;
        bus.pipeline_ready = 0;
        #1;
        chk("t5_occ", bus.occupancy, 2);
        step();
        bus.pipeline_ready = 1;
        #1;
        chk("t5_first", bus.issue_cq_index, 14);
        step();
        #1;
        chk("t5_second", bus.issue_cq_index, 15);
        step();
        // Reset while holding entries.
        bus.pipeline_ready = 0;
        set_enq(3, 4, 1, 1, 0, 0);
        step();
        set_enq(48, 0, 0, 0, 0, 1);
        step();
        set_enq(49, 0, 0, 0, 0, 1);
        step();
        bus.enq_valid = 0;
        RST = 1;
        bus.pipeline_ready = 1;
        #1;
        chk("t6_noissue", bus.issue_valid, 0);
        step();
        RST = 0;
        #1;
        chk("t6_occ", bus.occupancy, 0);
        step();
        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            int base, head, span, cls;
            RST = $urandom_range(0, 99) == 0;
            bus.pipeline_ready = $urandom_range(0, 9) < 7;
            for (int b = 0; b < 4; b++) begin
                bus.WB_bus_valid_by_bank[b] = $urandom_range(0, 9) < 3;
                bus.WB_bus_upper_PR_by_bank[b] = 5'($urandom_range(0, 3));
            end
            set_enq($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3) == 0,
                    $urandom_range(0, 3) == 0, $urandom_range(0, 6) == 0, $urandom_range(0, 6) == 0);
            cls = $urandom_range(0, 2);
            bus.enq_is_store = cls == 0;
            bus.enq_is_amo = cls == 1;
            bus.enq_is_fence = cls == 2;
            base = q.size() != 0 ? q[0].cq : next_cq;
            bus.enq_valid = $urandom_range(0, 9) < 6 && (next_cq - base + 16) % 16 < 10;
            bus.flush_valid = $urandom_range(0, 19) == 0;
            head = (base - int'($urandom_range(0, 3)) + 16) % 16;
            span = (next_cq - head + 16) % 16;
            bus.flush_cq_head = 4'(head);
            bus.flush_cq_index = 4'((head + int'($urandom_range(0, span))) % 16);
            step();
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/stamofu_iq_gen2.md
Name: stamofu_iq_gen2

Overview:
Parametrised store/AMO/fence issue queue between dispatch and the STAMOFU address pipeline. It holds ops in program order in a compacting shift queue, with entry 0 the oldest. Operand readiness is tracked by snooping the per-bank writeback bus. Each cycle it issues the oldest op whose operands are ready, driving PRF read requests. This generation adds parametrised depth, PR, bank and CQ widths, an occupancy output, and a flush port that kills younger entries by CQ age.

Parameters:
IQ_ENTRIES, 4, queue depth (>=2)
LOG_PR_COUNT, 7, physical register index width
LOG_PRF_BANK_COUNT, 2, log2 of PRF bank count; PRF_BANK_COUNT = 2**LOG_PRF_BANK_COUNT
LOG_CQ_ENTRIES, 4, STAMOFU CQ index width

Ports:
CLK  in  1  clock
RST  in  1  reset
enq_valid  in  1  enqueue request
enq_is_store / enq_is_amo / enq_is_fence  in  1 each  op class
enq_op  in  4  op subtype
enq_imm12  in  12  immediate
enq_A_PR / enq_B_PR  in  LOG_PR_COUNT  source PRs
enq_A_ready / enq_B_ready  in  1  operand already written
enq_A_is_zero / enq_B_is_zero  in  1  operand is x0 or unused
enq_cq_index  in  LOG_CQ_ENTRIES  CQ slot
enq_ready  out  1  enqueue accepted this cycle if enq_valid
WB_bus_valid_by_bank  in  PRF_BANK_COUNT  writeback valid per bank
WB_bus_upper_PR_by_bank  in  PRF_BANK_COUNT x (LOG_PR_COUNT-LOG_PRF_BANK_COUNT)  upper PR bits per bank
issue_valid  out  1  issue fires this cycle
issue_is_store / issue_is_amo / issue_is_fence  out  1 each
issue_op  out  4
issue_imm12  out  12
issue_A_forward / issue_B_forward  out  1  operand comes from this cycle's WB bus
issue_A_is_zero / issue_B_is_zero  out  1
issue_A_bank / issue_B_bank  out  LOG_PRF_BANK_COUNT  PR low bits
issue_cq_index  out  LOG_CQ_ENTRIES
PRF_req_A_valid / PRF_req_B_valid  out  1  PRF read request
PRF_req_A_PR / PRF_req_B_PR  out  LOG_PR_COUNT
pipeline_ready  in  1  downstream can accept
flush_valid  in  1  kill younger ops
flush_cq_index  in  LOG_CQ_ENTRIES  first killed CQ index
flush_cq_head  in  LOG_CQ_ENTRIES  current CQ head (oldest)
occupancy  out  $clog2(IQ_ENTRIES+1)  valid entry count

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high. While RST is high at a CLK edge, all entries are invalidated and occupancy becomes 0.
- Outputs while RST is high: enq_ready=0, issue_valid=0, PRF_req_*_valid=0. All other outputs are 0 while the queue is empty.
- Entry fields: valid, class bits, op, imm12, A/B PR, A/B ready, A/B is_zero, cq_index. The queue is always a valid prefix with no holes.
- Wakeup match for operand X: WB_bus_valid_by_bank[X_PR[LOG_PRF_BANK_COUNT-1:0]] && upper_PR_by_bank[bank] == X_PR[LOG_PR_COUNT-1:LOG_PRF_BANK_COUNT].
  - A match sets X_ready at the edge.
  - A match also applies to an entry being enqueued in the same cycle.
- Operand usable: ready | is_zero | wakeup match this cycle.
- Entry eligible: valid and both operands usable.
- Selection: the lowest-index eligible entry is selected.
- Issue handshake: issue_valid = selected exists && pipeline_ready && !flush_valid. Issue outputs are combinational from the selected entry.
  - X_forward = !ready && !is_zero && match.
  - PRF_req_X_valid = issue_valid && !X_forward && !X_is_zero.
  - PRF_req_X_PR = entry X_PR.
- Dequeue: when issue_valid, the issued entry is removed at the edge and entries above it shift down by one.
- Enqueue: enq_ready = !RST && !flush_valid && occupancy < IQ_ENTRIES. There is no same-cycle issue credit: a full queue refuses enqueue even if it issues.
  - An accepted op is written at index occupancy, or occupancy-1 if an issue occurs the same cycle.
  - An accepted op is never issuable in its enqueue cycle (minimum 1-cycle enqueue-to-issue).
- Flush: age(i) = (i - flush_cq_head) mod 2**LOG_CQ_ENTRIES. An entry is killed if age(cq_index) >= age(flush_cq_index).
  - Ops are in program order, so killed entries form a suffix; occupancy becomes the surviving count.
  - In a flush cycle: no issue, no enqueue. Wakeups to surviving entries still apply.
  - flush_cq_index == flush_cq_head kills all entries.
- occupancy is registered and updated as old + enq_accept - issue, or the surviving count on flush.
- Arithmetic: CQ age is a modulo subtract at LOG_CQ_ENTRIES bits with natural wrap.

Test Plan:
- Reset/empty: assert RST for 2 cycles, then enqueue a store with A_ready=B_ready=1, PR 5/9 -> next cycle issue_valid=1, A_bank=1, B_bank=1, PRF_req_A_PR=5, PRF_req_B_PR=9, forward=0; occupancy 1->0.
- Wakeup/forward: enqueue with A not ready, A_PR=0x0E, 4 banks; after 3 idle cycles drive WB bank 2 with upper=3 -> issue that same cycle with A_forward=1, PRF_req_A_valid=0.
- Ordering/backpressure: fill 4 ready entries with cq 0..3, hold pipeline_ready=0 -> enq_ready=0, occupancy=4. Release -> issues cq 0,1,2,3 on consecutive cycles.
- Out-of-order issue: entry0 not ready, entry1 ready -> entry1 issues. Entry0 stays at index 0 and the later enqueue lands at index 1.
- Flush wrap: head=14, entries cq 14,15,0,1; flush_cq_index=0 -> cq 0,1 killed, occupancy=2, no issue and enq_ready=0 that cycle.
- Mid-operation reset: RST high with 3 valid entries, one ready, pipeline_ready=1 -> issue_valid=0 that cycle, occupancy=0 afterwards.
